// File: rtl/div_issue_ctrl_if.sv
// Core-side request/response bundle of div_issue_ctrl (signal suffixes are from the controller's view).
interface div_issue_ctrl_if #(
  parameter int C_WIDTH = 32
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload are held by the sender until then, and ready never waits on a transfer.
  logic               ReqVld_SI;
  logic               ReqRdy_SO;
  logic [C_WIDTH-1:0] OpA_DI;
  logic [C_WIDTH-1:0] OpB_DI;
  logic [1:0]         OpCode_SI;
  logic               Flush_SI;
  logic               RspVld_SO;
  logic               RspRdy_SI;
  logic [C_WIDTH-1:0] Rsp_DO;

  modport master (
    output ReqVld_SI, OpA_DI, OpB_DI, OpCode_SI, Flush_SI, RspRdy_SI,
    input  ReqRdy_SO, RspVld_SO, Rsp_DO
  );

  modport slave (
    input  ReqVld_SI, OpA_DI, OpB_DI, OpCode_SI, Flush_SI, RspRdy_SI,
    output ReqRdy_SO, RspVld_SO, Rsp_DO
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/result-buffer stage around the serial divider: latches operands, normalises the divisor,
// pulses the start, then holds the result for the core. DIV_ZERO_BYPASS_EN answers B==0 locally.
module div_issue_ctrl #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  div_issue_ctrl_if.slave        core_if,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  input  logic                   DivOutVld_SI,
  output logic                   DivOutRdy_SO,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic [2:0]             DbgState_SO
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [C_WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]             opc_q, opc_d;
  logic                   discard_q, discard_d;
  logic [C_WIDTH-1:0]     div_opa_q, div_opa_d, div_opb_q, div_opb_d;
  logic [C_LOG_WIDTH-1:0] shift_q, shift_d;
  logic                   zero_q, zero_d, sign_q, sign_d;
  logic [1:0]             div_opc_q, div_opc_d;
  logic [C_WIDTH-1:0]     rsp_q, rsp_d;

  // Signed divisors skip the sign bit and count copies of it, so B<<shift keeps B recoverable by >>>.
  function automatic logic [C_LOG_WIDTH-1:0] lead_cnt(input logic [C_WIDTH-1:0] b, input logic sgn);
    logic [C_LOG_WIDTH-1:0] cnt;
    logic                   run;
    logic                   ref_bit;
    cnt     = '0;
    run     = 1'b1;
    ref_bit = sgn & b[C_WIDTH-1];
    for (int i = C_WIDTH - 1; i >= 0; i--) begin
      if (!(sgn && (i == C_WIDTH - 1))) begin
        if (run && (b[i] == ref_bit)) cnt = cnt + C_LOG_WIDTH'(1);
        else run = 1'b0;
      end
    end
    return cnt;
  endfunction

  logic                   prep_signed, prep_zero;
  logic [C_LOG_WIDTH-1:0] prep_shift;

  assign prep_signed = opc_q[0];
  assign prep_zero   = (b_q == '0);
  assign prep_shift  = prep_zero ? C_LOG_WIDTH'(C_WIDTH) : lead_cnt(b_q, prep_signed);

`ifdef DIV_ZERO_BYPASS_EN
  logic [C_WIDTH-1:0] zero_rsp;
  assign zero_rsp = opc_q[1] ? a_q : '1;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    opc_d     = opc_q;
    discard_d = discard_q;
    div_opa_d = div_opa_q;
    div_opb_d = div_opb_q;
    shift_d   = shift_q;
    zero_d    = zero_q;
    sign_d    = sign_q;
    div_opc_d = div_opc_q;
    rsp_d     = rsp_q;
    case (state_q)
      S_IDLE: begin
        if (core_if.ReqVld_SI) begin
          a_d       = core_if.OpA_DI;
          b_d       = core_if.OpB_DI;
          opc_d     = core_if.OpCode_SI;
          discard_d = 1'b0;
          state_d   = S_PREP;
        end
      end
      S_PREP: begin
        if (core_if.Flush_SI) begin
          state_d = S_IDLE;
        end else begin
          div_opa_d = a_q;
          div_opb_d = b_q << prep_shift;
          shift_d   = prep_shift;
          zero_d    = prep_zero;
          sign_d    = prep_signed & b_q[C_WIDTH-1];
          div_opc_d = opc_q;
          state_d   = S_ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
          if (prep_zero) begin
            rsp_d   = zero_rsp;
            state_d = S_RESP;
          end
`endif
        end
      end
      // The divider cannot be aborted once started, so a flush here only marks the result for dropping.
      S_ISSUE: begin
        if (core_if.Flush_SI) discard_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (DivOutVld_SI) begin
          if (discard_q || core_if.Flush_SI) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            rsp_d   = DivRes_DI;
            state_d = S_RESP;
          end
        end else if (core_if.Flush_SI) begin
          discard_d = 1'b1;
        end
      end
      S_RESP: begin
        if (core_if.Flush_SI || core_if.RspRdy_SI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      opc_q     <= '0;
      discard_q <= 1'b0;
      div_opa_q <= '0;
      div_opb_q <= '0;
      shift_q   <= '0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      div_opc_q <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opc_q     <= opc_d;
      discard_q <= discard_d;
      div_opa_q <= div_opa_d;
      div_opb_q <= div_opb_d;
      shift_q   <= shift_d;
      zero_q    <= zero_d;
      sign_q    <= sign_d;
      div_opc_q <= div_opc_d;
      rsp_q     <= rsp_d;
    end
  end

  assign core_if.ReqRdy_SO = (state_q == S_IDLE);
  assign core_if.RspVld_SO = (state_q == S_RESP);
  assign core_if.Rsp_DO    = rsp_q;
  assign DivInVld_SO       = (state_q == S_ISSUE);
  assign DivOutRdy_SO      = (state_q == S_WAIT);
  assign DivOpA_DO         = div_opa_q;
  assign DivOpB_DO         = div_opb_q;
  assign DivOpBShift_DO    = shift_q;
  assign DivOpBIsZero_SO   = zero_q;
  assign DivOpBSign_SO     = sign_q;
  assign DivOpCode_SO      = div_opc_q;
  assign DbgState_SO       = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural serial-divider model on the divider side.
module tb_div_issue_ctrl;

  logic clk;
  logic rst_n;

  div_issue_ctrl_if #(.C_WIDTH(32)) core_if ();

  logic [31:0] div_opa, div_opb, div_res;
  logic [5:0]  div_shift;
  logic        div_zero, div_sign, div_in_vld, div_out_vld, div_out_rdy;
  logic [1:0]  div_opc;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  div_issue_ctrl dut (
    .Clk_CI          (clk),
    .Rst_RBI         (rst_n),
    .core_if         (core_if),
    .DivOpA_DO       (div_opa),
    .DivOpB_DO       (div_opb),
    .DivOpBShift_DO  (div_shift),
    .DivOpBIsZero_SO (div_zero),
    .DivOpBSign_SO   (div_sign),
    .DivOpCode_SO    (div_opc),
    .DivInVld_SO     (div_in_vld),
    .DivOutVld_SI    (div_out_vld),
    .DivOutRdy_SO    (div_out_rdy),
    .DivRes_DI       (div_res),
    .DbgState_SO     (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // divider model: undoes the normalisation and answers shift+2 cycles after the start pulse
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] bn,
                                            input logic [5:0] sh, input logic [1:0] opc);
    logic [31:0]        b;
    logic signed [31:0] sa, sb;
    if (sh >= 6'd32) b = '0;
    else if (opc[0]) begin
      sb = $signed(bn);
      sb = sb >>> sh;
      b  = sb;
    end else b = bn >> sh;
    sa = a;
    sb = b;
    if (b == 32'd0) return opc[1] ? a : 32'hFFFF_FFFF;
    if (opc[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return opc[1] ? 32'h0 : a;
      return opc[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return opc[1] ? a % b : a / b;
  endfunction

  logic busy;
  int   cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      cnt         <= 0;
      div_out_vld <= 1'b0;
      div_res     <= '0;
    end else begin
      if (div_out_vld && div_out_rdy) div_out_vld <= 1'b0;
      if (div_in_vld) begin
        busy    <= 1'b1;
        cnt     <= int'(div_shift) + 1;
        div_res <= model_div(div_opa, div_opb, div_shift, div_opc);
      end else if (busy) begin
        if (cnt == 1) begin
          busy        <= 1'b0;
          div_out_vld <= 1'b1;
        end else cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_reqrdy"}, core_if.ReqRdy_SO, 1);
    chk({tag, "_rspvld"}, core_if.RspVld_SO, 0);
    chk({tag, "_rsp"}, core_if.Rsp_DO, 0);
    chk({tag, "_invld"}, div_in_vld, 0);
    chk({tag, "_outrdy"}, div_out_rdy, 0);
    chk({tag, "_opa"}, div_opa, 0);
    chk({tag, "_opb"}, div_opb, 0);
    chk({tag, "_shift"}, div_shift, 0);
    chk({tag, "_sign"}, div_sign, 0);
    chk({tag, "_zero"}, div_zero, 0);
  endtask

  // driver: present a request and wait (bounded) for the handshake; returns at cycle 1 (PREP)
  task automatic send_req(input string tag, input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    int   n;
    core_if.ReqVld_SI = 1'b1;
    core_if.OpCode_SI = opc;
    core_if.OpA_DI    = a;
    core_if.OpB_DI    = b;
    n = 0;
    do begin
      ok = core_if.ReqRdy_SO;
      step();
      n++;
    end while (!ok && n < 100);
    core_if.ReqVld_SI = 1'b0;
    chk({tag, "_accept"}, ok, 1);
  endtask

  // wait for the response, checking issue fields, latency and the scoreboarded result
  task automatic wait_rsp(input string tag, input logic [31:0] exp_rsp, input int exp_lat,
                          input int exp_iss, input logic [31:0] exp_opa, input logic [1:0] exp_opc,
                          input logic [5:0] exp_sh, input logic [31:0] exp_opb,
                          input logic exp_sign, input logic exp_zero, input logic do_release);
    int n, iss;
    exp_q.push_back(exp_rsp);
    n   = 1;
    iss = 0;
    while (!core_if.RspVld_SO && n < 300) begin
      if (div_in_vld) begin
        iss++;
        chk({tag, "_opa"}, div_opa, exp_opa);
        chk({tag, "_opc"}, div_opc, exp_opc);
        chk({tag, "_shift"}, div_shift, exp_sh);
        chk({tag, "_opb"}, div_opb, exp_opb);
        chk({tag, "_sign"}, div_sign, exp_sign);
        chk({tag, "_zero"}, div_zero, exp_zero);
      end
      step();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_issues"}, iss, exp_iss);
    chk({tag, "_rsp"}, core_if.Rsp_DO, exp_q.pop_front());
    if (do_release) begin
      core_if.RspRdy_SI = 1'b1;
      step();
      core_if.RspRdy_SI = 1'b0;
      chk({tag, "_done_rspvld"}, core_if.RspVld_SO, 0);
      chk({tag, "_done_reqrdy"}, core_if.ReqRdy_SO, 1);
    end
  endtask

  // flush at cycle flush_cyc; the result must be dropped and the controller idle after DivOutVld
  task automatic flush_op(input string tag, input int flush_cyc);
    int   n, pulses;
    logic seen_rsp, seen_out;
    send_req(tag, 2'd0, 32'd100, 32'd7);
    n        = 1;
    pulses   = 0;
    seen_rsp = 1'b0;
    seen_out = 1'b0;
    while (n < 200 && !seen_out) begin
      core_if.Flush_SI = (n == flush_cyc);
      if (div_in_vld) pulses++;
      if (core_if.RspVld_SO) seen_rsp = 1'b1;
      if (div_out_vld) seen_out = 1'b1;
      step();
      n++;
    end
    core_if.Flush_SI = 1'b0;
    chk({tag, "_outvld_seen"}, seen_out, 1);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_no_rsp"}, seen_rsp, 0);
    chk({tag, "_reqrdy"}, core_if.ReqRdy_SO, 1);
    chk({tag, "_rspvld"}, core_if.RspVld_SO, 0);
  endtask

  initial begin
    int zlat, ziss;
`ifdef DIV_ZERO_BYPASS_EN
    zlat = 2;
    ziss = 0;
`else
    zlat = 37;
    ziss = 1;
`endif
    // reset
    rst_n             = 1'b0;
    core_if.ReqVld_SI = 1'b0;
    core_if.OpA_DI    = '0;
    core_if.OpB_DI    = '0;
    core_if.OpCode_SI = '0;
    core_if.Flush_SI  = 1'b0;
    core_if.RspRdy_SI = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    chk_reset_vals("post_reset");

    // unsigned and signed directed vectors
    send_req("udiv_100_7", 2'd0, 32'd100, 32'd7);
    wait_rsp("udiv_100_7", 32'd14, 34, 1, 32'd100, 2'd0, 6'd29, 32'hE000_0000, 1'b0, 1'b0, 1'b1);
    send_req("urem_100_7", 2'd2, 32'd100, 32'd7);
    wait_rsp("urem_100_7", 32'd2, 34, 1, 32'd100, 2'd2, 6'd29, 32'hE000_0000, 1'b0, 1'b0, 1'b1);
    send_req("div_m7_2", 2'd1, 32'hFFFF_FFF9, 32'd2);
    wait_rsp("div_m7_2", 32'hFFFF_FFFD, 34, 1, 32'hFFFF_FFF9, 2'd1, 6'd29, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    send_req("rem_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_rsp("rem_m7_2", 32'hFFFF_FFFF, 34, 1, 32'hFFFF_FFF9, 2'd3, 6'd29, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    send_req("div_m7_m2", 2'd1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    wait_rsp("div_m7_m2", 32'd3, 35, 1, 32'hFFFF_FFF9, 2'd1, 6'd30, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    send_req("div_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rsp("div_ovf", 32'h8000_0000, 36, 1, 32'h8000_0000, 2'd1, 6'd31, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

    // divide by zero
    send_req("udiv_5_0", 2'd0, 32'd5, 32'd0);
    wait_rsp("udiv_5_0", 32'hFFFF_FFFF, zlat, ziss, 32'd5, 2'd0, 6'd32, 32'h0, 1'b0, 1'b1, 1'b1);
    send_req("urem_5_0", 2'd2, 32'd5, 32'd0);
    wait_rsp("urem_5_0", 32'd5, zlat, ziss, 32'd5, 2'd2, 6'd32, 32'h0, 1'b0, 1'b1, 1'b1);

    // response backpressure with a second request stalled behind it
    send_req("bp_first", 2'd0, 32'd100, 32'd7);
    wait_rsp("bp_first", 32'd14, 34, 1, 32'd100, 2'd0, 6'd29, 32'hE000_0000, 1'b0, 1'b0, 1'b0);
    core_if.ReqVld_SI = 1'b1;
    core_if.OpCode_SI = 2'd0;
    core_if.OpA_DI    = 32'd9;
    core_if.OpB_DI    = 32'd3;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_rsp", core_if.Rsp_DO, 32'd14);
      chk("bp_hold_rspvld", core_if.RspVld_SO, 1);
      chk("bp_hold_reqrdy", core_if.ReqRdy_SO, 0);
      step();
    end
    core_if.RspRdy_SI = 1'b1;
    step();
    core_if.RspRdy_SI = 1'b0;
    chk("bp_release_rspvld", core_if.RspVld_SO, 0);
    chk("bp_release_reqrdy", core_if.ReqRdy_SO, 1);
    step();
    core_if.ReqVld_SI = 1'b0;
    chk("bp_second_taken", core_if.ReqRdy_SO, 0);
    wait_rsp("bp_second", 32'd3, 35, 1, 32'd9, 2'd0, 6'd30, 32'hC000_0000, 1'b0, 1'b0, 1'b1);

    // flush in ISSUE and in WAIT
    flush_op("flush_issue", 2);
    send_req("after_fl_issue", 2'd0, 32'd9, 32'd3);
    wait_rsp("after_fl_issue", 32'd3, 35, 1, 32'd9, 2'd0, 6'd30, 32'hC000_0000, 1'b0, 1'b0, 1'b1);
    flush_op("flush_wait", 10);
    send_req("after_fl_wait", 2'd0, 32'd9, 32'd3);
    wait_rsp("after_fl_wait", 32'd3, 35, 1, 32'd9, 2'd0, 6'd30, 32'hC000_0000, 1'b0, 1'b0, 1'b1);

    // asynchronous reset in the middle of WAIT
    send_req("rst_mid", 2'd0, 32'd100, 32'd7);
    repeat (5) step();
    chk("rst_mid_in_wait", div_out_rdy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    send_req("after_rst", 2'd0, 32'd1, 32'd1);
    wait_rsp("after_rst", 32'd1, 36, 1, 32'd1, 2'd0, 6'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    // report
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Front-end and result-buffer stage placed directly upstream and downstream of the serial divider (`riscv_alu_div`).
- Accepts div/rem requests from the ALU/EX stage over a valid/ready handshake and registers the operands.
- Computes the divider's normalisation inputs (shift count, B-is-zero flag, sign gating), issues a one-cycle start pulse, then captures the divider result and holds it for the core until consumed.

Parameters:
- C_WIDTH, 32, operand/result width.
- C_LOG_WIDTH, 6, width of the shift count; equals $clog2(C_WIDTH+1).

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- ReqVld_SI  in  1  request valid.
- ReqRdy_SO  out  1  request ready.
- OpA_DI  in  C_WIDTH  dividend.
- OpB_DI  in  C_WIDTH  divisor.
- OpCode_SI  in  2  0 udiv, 1 div, 2 urem, 3 rem.
- Flush_SI  in  1  discard the in-flight operation.
- DivOpA_DO  out  C_WIDTH  dividend to divider.
- DivOpB_DO  out  C_WIDTH  normalised divisor.
- DivOpBShift_DO  out  C_LOG_WIDTH  iteration count.
- DivOpBIsZero_SO  out  1  divisor is zero.
- DivOpBSign_SO  out  1  divisor sign, gated to 0 for unsigned ops.
- DivOpCode_SO  out  2  opcode to divider.
- DivInVld_SO  out  1  start pulse.
- DivOutVld_SI  in  1  divider result valid.
- DivOutRdy_SO  out  1  divider result accept.
- DivRes_DI  in  C_WIDTH  divider result.
- RspVld_SO  out  1  response valid.
- RspRdy_SI  in  1  response ready.
- Rsp_DO  out  C_WIDTH  quotient or remainder.

Behaviour:
- Reset: state IDLE. All registered outputs are 0: ReqRdy_SO=1 (combinational from IDLE), RspVld_SO=0, DivInVld_SO=0, DivOutRdy_SO=0, Rsp_DO=0, Div* operand outputs=0, Discard flag=0.
- States:
  - IDLE: ReqRdy=1. On ReqVld, latch A, B, OpCode, then go to PREP. Flush has no effect.
  - PREP (1 cycle): compute and register the divider inputs.
    - Signed = OpCode[0].
    - Sign = Signed & B[MSB].
    - IsZero = (B==0).
    - Shift = clz(B) for unsigned; for signed, count of leading bits equal to B[MSB] beyond the sign bit.
    - B==0 gives Shift=C_WIDTH.
    - DivOpB = B << Shift, truncated to C_WIDTH.
    - Next state is ISSUE. On Flush, go to IDLE instead.
  - ISSUE (1 cycle): DivInVld=1, then go to WAIT. Flush sets Discard and still issues, because the divider cannot be aborted once its inputs are presented.
  - WAIT: DivOutRdy=1.
    - The first WAIT cycle is guaranteed to see DivOutVld=0, because the divider's IDLE-valid is masked by ordering.
    - On DivOutVld: if Discard, clear it and go to IDLE. Otherwise register Rsp=DivRes and go to RESP.
    - Flush in WAIT sets Discard.
  - RESP: RspVld=1; Rsp_DO is held stable.
    - On RspRdy, go to IDLE.
    - Flush in RESP drops the response and goes to IDLE.
    - RspRdy and Flush in the same cycle: Flush wins, and the response is not counted as delivered.
- Latency:
  - Request accepted at cycle 0.
  - DivInVld asserted at cycle 2.
  - RspVld asserted at cycle Shift+5.
  - Back-to-back operation: a new request is accepted in the IDLE cycle after the RspRdy handshake. One op is in flight at most.
- ReqRdy=1 only in IDLE; no request is queued.
- Result passes through unmodified. -2^31 / -1 returns whatever the divider produces; no special case.
- Reset mid-operation: asynchronous return to IDLE. The divider shares Rst_RBI, so no drain is required.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined:
  - In PREP, when IsZero, the divider is not issued; go straight to RESP.
  - Rsp = all-ones for udiv/div, and Rsp = A for urem/rem (RISC-V semantics).
  - RspVld is asserted at cycle 2.
  - Flush behaviour is unchanged.
- Undefined: B==0 is issued normally with DivOpBIsZero=1, and the divider result is returned.

Test Plan:
- udiv A=100, B=7 -> DivOpBShift=29, RspVld at cycle 34, Rsp=14; repeat as urem -> Rsp=2.
- div A=-7 (0xFFFFFFF9), B=2 -> Rsp=0xFFFFFFFD (-3); rem -> Rsp=0xFFFFFFFF (-1); DivOpBSign=0. Also div B=-2 -> DivOpBSign=1, Rsp=3.
- udiv A=5, B=0; urem A=5, B=0 -> Rsp=0xFFFFFFFF and Rsp=5 respectively.
  - With DIV_ZERO_BYPASS_EN: RspVld at cycle 2, DivInVld never asserted.
  - Without DIV_ZERO_BYPASS_EN: DivOpBIsZero=1 and Shift=32.
- Backpressure: hold RspRdy=0 for 10 cycles after RspVld -> Rsp_DO stable, ReqRdy=0, a second request stalls. It is accepted the cycle after RspRdy=1.
- Flush asserted in ISSUE and separately in WAIT -> DivInVld pulses once, no RspVld, ReqRdy returns 1 the cycle after DivOutVld. The next request udiv 9/3 returns 3.
- Assert Rst_RBI=0 mid-WAIT -> all outputs return to reset values asynchronously. After release, udiv 1/1 returns 1.
